// File: rtl/bin_to_oct_driver.sv
// bin_to_oct_driver
// Turns queued 3-bit binary codes into one-hot drive on an 8-bit Oct bus.
// Codes are accepted on a valid/ready handshake into a small FIFO. Each
// popped code is held on oct for max(dwell,1) cycles and is followed by one
// all-zero gap cycle.
//
// Optional build macro OCT_LOOPBACK_CHECK_EN adds a sticky err output. A
// priority encoder re-encodes the driven oct value every cycle, and err sets
// if that value disagrees with the popped code while driving.
//
// All outputs come from registers. An asynchronous reset therefore forces
// them to their idle values at once, even in the middle of a symbol.

module bin_to_oct_driver #(
    parameter int FIFO_DEPTH = 4,
    parameter int DWELL_W    = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [2:0]                    in_bin,
    input  logic [DWELL_W-1:0]            dwell,
    output logic [7:0]                    oct,
    output logic                          oct_valid,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef OCT_LOOPBACK_CHECK_EN
    ,
    output logic                          err
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [LVL_W-1:0]   LVL_ZERO = {LVL_W{1'b0}};
    localparam logic [LVL_W-1:0]   LVL_ONE  = {{(LVL_W-1){1'b0}}, 1'b1};
    localparam logic [LVL_W-1:0]   LVL_FULL = LVL_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0]   PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [DWELL_W-1:0] CNT_ZERO = {DWELL_W{1'b0}};
    localparam logic [DWELL_W-1:0] CNT_ONE  = {{(DWELL_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // One-hot decode of a 3-bit code onto the Oct bus.
    function automatic logic [7:0] oct_decode(input logic [2:0] code);
        oct_decode = 8'b0000_0001 << code;
    endfunction

    // True when exactly one bit of the bus is set.
    function automatic logic oct_is_onehot(input logic [7:0] v);
        oct_is_onehot = (v != 8'h00) && ((v & (v - 8'h01)) == 8'h00);
    endfunction

    // ---------------------------------------------------------------------
    // Storage
    // ---------------------------------------------------------------------
    logic [2:0]         fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [LVL_W-1:0]   level_r;

    state_t             state_r;
    logic [DWELL_W-1:0] cnt_r;
    logic [2:0]         code_r;

    logic [7:0]         oct_r;
    logic               oct_valid_r;
    logic               busy_r;
    logic               in_ready_r;

    // ---------------------------------------------------------------------
    // Combinational next values
    // ---------------------------------------------------------------------
    logic               push_s;
    logic               pop_s;
    logic [2:0]         head_code_s;
    logic [DWELL_W-1:0] dwell_eff_s;
    logic [LVL_W-1:0]   level_next_s;

    state_t             state_next_s;
    logic [DWELL_W-1:0] cnt_next_s;
    logic [2:0]         code_next_s;

    logic [7:0]         oct_next_s;
    logic               oct_valid_next_s;
    logic               busy_next_s;
    logic               in_ready_next_s;

    // A push needs the registered ready flag, so a pop in the same cycle
    // cannot open a full FIFO. Pops happen only from IDLE.
    assign push_s      = in_valid && in_ready_r;
    assign pop_s       = (state_r == ST_IDLE) && (level_r != LVL_ZERO);
    assign head_code_s = fifo_mem_r[rd_ptr_r];
    assign dwell_eff_s = (dwell == CNT_ZERO) ? CNT_ONE : dwell;

    // FIFO occupancy after this cycle's push/pop.
    always_comb begin
        level_next_s = level_r;
        case ({push_s, pop_s})
            2'b10:   level_next_s = level_r + LVL_ONE;
            2'b01:   level_next_s = level_r - LVL_ONE;
            default: level_next_s = level_r;
        endcase
    end

    // Next-state logic: IDLE pops, DRIVE counts the dwell down, GAP lasts one cycle.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        code_next_s  = code_r;
        case (state_r)
            ST_IDLE: begin
                if (pop_s) begin
                    state_next_s = ST_DRIVE;
                    code_next_s  = head_code_s;
                    cnt_next_s   = dwell_eff_s;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                // <= also catches a corrupted zero count, so DRIVE cannot stick.
                if (cnt_r <= CNT_ONE) begin
                    state_next_s = ST_GAP;
                    cnt_next_s   = CNT_ZERO;
                end else begin
                    cnt_next_s   = cnt_r - CNT_ONE;
                end
            end
            ST_GAP: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = CNT_ZERO;
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = CNT_ZERO;
            end
        endcase
    end

    // Output decode from the next state. The registered outputs therefore
    // line up with the state they describe.
    always_comb begin
        oct_next_s       = 8'h00;
        oct_valid_next_s = 1'b0;
        case (state_next_s)
            ST_DRIVE: begin
                oct_next_s       = oct_decode(code_next_s);
                oct_valid_next_s = 1'b1;
            end
            ST_IDLE, ST_GAP: begin
                oct_next_s       = 8'h00;
                oct_valid_next_s = 1'b0;
            end
            default: begin
                oct_next_s       = 8'h00;
                oct_valid_next_s = 1'b0;
            end
        endcase
        busy_next_s     = (state_next_s != ST_IDLE) || (level_next_s != LVL_ZERO);
        in_ready_next_s = (level_next_s != LVL_FULL);
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------

    // FIFO storage, pointers and occupancy. Pointers wrap at the power-of-2 depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= 3'd0;
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= LVL_ZERO;
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= in_bin;
                wr_ptr_r             <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            level_r <= level_next_s;
        end
    end

    // State register, dwell counter and the latched current code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            code_r  <= 3'd0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            code_r  <= code_next_s;
        end
    end

    // Registered outputs. Reset puts them at their idle values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oct_r       <= 8'h00;
            oct_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            oct_r       <= oct_next_s;
            oct_valid_r <= oct_valid_next_s;
            busy_r      <= busy_next_s;
            in_ready_r  <= in_ready_next_s;
        end
    end

    assign oct        = oct_r;
    assign oct_valid  = oct_valid_r;
    assign busy       = busy_r;
    assign in_ready   = in_ready_r;
    assign fifo_level = level_r;

`ifdef OCT_LOOPBACK_CHECK_EN
    // Priority re-encode of the Oct bus. The highest set bit wins.
    function automatic logic [2:0] oct_encode(input logic [7:0] v);
        logic [2:0] code;
        code = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
                code = 3'(i);
            end else begin
                code = code;
            end
        end
        oct_encode = code;
    endfunction

    logic       err_r;
    logic       mismatch_s;
    logic [2:0] reenc_s;

    assign reenc_s    = oct_encode(oct_r);
    assign mismatch_s = (state_r == ST_DRIVE) &&
                        ((reenc_s != code_r) || !oct_is_onehot(oct_r));

    // Sticky loopback error. Only rst_n clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else if (mismatch_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign err = err_r;
`endif

endmodule

// File: tb/tb_bin_to_oct_driver.sv
// Directed self-checking bench for bin_to_oct_driver (default parameters).
module tb_bin_to_oct_driver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_bin;
    logic [3:0] dwell;
    logic [7:0] oct;
    logic       oct_valid;
    logic       busy;
    logic [2:0] fifo_level;
`ifdef OCT_LOOPBACK_CHECK_EN
    logic       err;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Collector results
    logic [7:0] sym_q[$];
    int         len_q[$];
    int         start_q[$];
    int         shape_bad;
    int         ready_bad;
    int         max_level;
    bit         saw_low;
    bit         recovered;

    bin_to_oct_driver #(.FIFO_DEPTH(4), .DWELL_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_bin     (in_bin),
        .dwell      (dwell),
        .oct        (oct),
        .oct_valid  (oct_valid),
        .busy       (busy),
        .fifo_level (fifo_level)
`ifdef OCT_LOOPBACK_CHECK_EN
        ,
        .err        (err)
`endif
    );

    always #5 clk = ~clk;

    // Offer one code. The push lands on the edge after in_ready is seen high.
    task automatic push_code(input logic [2:0] c, input int limit, output int waited);
        in_valid = 1'b1;
        in_bin   = c;
        waited   = 0;
        while (!in_ready && waited < limit) begin
            @(posedge clk); #1;
            waited++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Record symbol runs and per-cycle output shape for ncyc cycles.
    task automatic collect(input int ncyc);
        int run;
        run = 0;
        sym_q.delete(); len_q.delete(); start_q.delete();
        shape_bad = 0; ready_bad = 0; max_level = 0; saw_low = 0; recovered = 0;
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            @(posedge clk); #1;
            if (oct_valid === 1'b1) begin
                if (!((oct != 8'h00) && ((oct & (oct - 8'h01)) == 8'h00))) shape_bad++;
                if (run == 0) begin
                    sym_q.push_back(oct);
                    start_q.push_back(cyc);
                end else if (oct !== sym_q[$]) begin
                    shape_bad++;
                end
                run++;
            end else begin
                if (oct !== 8'h00) shape_bad++;
                if (run != 0) begin
                    len_q.push_back(run);
                    run = 0;
                end
            end
            if (in_ready !== (fifo_level != 3'd4)) ready_bad++;
            if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
            if (in_ready === 1'b0) saw_low = 1'b1;
            else if (saw_low) recovered = 1'b1;
        end
        if (run != 0) len_q.push_back(run);
    endtask

    task automatic test_reset();
        rst_n = 1'b1; in_valid = 1'b0; in_bin = 3'd0; dwell = 4'd0;
        #2 rst_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (i == 2) rst_n = 1'b1;
            n_cmp++;
            if ({oct, oct_valid, busy, fifo_level, in_ready} !== {8'h00, 1'b0, 1'b0, 3'd0, 1'b1}) begin
                n_err++;
                $display("FAIL reset_idle cyc %0d: got oct=%h v=%b busy=%b lvl=%0d rdy=%b want 00/0/0/0/1",
                         i, oct, oct_valid, busy, fifo_level, in_ready);
            end
        end
    endtask

    task automatic test_single();
        dwell = 4'd3; in_valid = 1'b1; in_bin = 3'b101;
        @(posedge clk); #1;              // edge k
        in_valid = 1'b0;
        n_cmp++;
        if ({oct_valid, busy, fifo_level} !== {1'b0, 1'b1, 3'd1}) begin
            n_err++;
            $display("FAIL single_k: got v=%b busy=%b lvl=%0d want 0/1/1", oct_valid, busy, fifo_level);
        end
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({oct, oct_valid} !== {8'b0010_0000, 1'b1}) begin
                n_err++;
                $display("FAIL single_drive k+%0d: got oct=%h v=%b want 20/1", i, oct, oct_valid);
            end
            dwell = 4'd9;                // must not stretch the current symbol
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({oct, oct_valid, busy} !== {8'h00, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL single_gap: got oct=%h v=%b busy=%b want 00/0/1", oct, oct_valid, busy);
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({busy, fifo_level, oct_valid} !== {1'b0, 3'd0, 1'b0}) begin
            n_err++;
            $display("FAIL single_idle: got busy=%b lvl=%0d v=%b want 0/0/0", busy, fifo_level, oct_valid);
        end
    endtask

    task automatic test_sweep();
        logic [7:0] exp;
        dwell = 4'd0;
        fork
            begin
                int w;
                for (int c = 0; c < 8; c++) push_code(3'(c), 60, w);
            end
            collect(40);
        join
        n_cmp++;
        if (sym_q.size() != 8) begin
            n_err++;
            $display("FAIL sweep_count: got %0d symbols want 8", sym_q.size());
        end
        for (int i = 0; i < sym_q.size() && i < 8; i++) begin
            exp = 8'h01;
            exp = exp << i;
            n_cmp++;
            if (sym_q[i] !== exp) begin
                n_err++;
                $display("FAIL sweep_sym %0d: got %h want %h", i, sym_q[i], exp);
            end
        end
        for (int i = 0; i < len_q.size(); i++) begin
            n_cmp++;
            if (len_q[i] != 1) begin
                n_err++;
                $display("FAIL sweep_len %0d: got %0d want 1", i, len_q[i]);
            end
        end
        for (int i = 1; i < start_q.size(); i++) begin
            n_cmp++;
            if (start_q[i] - start_q[i-1] != 3) begin
                n_err++;
                $display("FAIL sweep_spacing %0d: got %0d want 3", i, start_q[i] - start_q[i-1]);
            end
        end
        n_cmp++;
        if ({shape_bad, ready_bad, max_level} != {32'd0, 32'd0, 32'd4} || !saw_low || !recovered) begin
            n_err++;
            $display("FAIL sweep_flow: got shape_bad=%0d ready_bad=%0d max_lvl=%0d low=%b rec=%b want 0/0/4/1/1",
                     shape_bad, ready_bad, max_level, saw_low, recovered);
        end
    endtask

    task automatic test_fifo_full();
        logic [2:0] codes [6];
        int         waits [6];
        codes = '{3'd3, 3'd7, 3'd0, 3'd5, 3'd2, 3'd6};
        dwell = 4'd15;
        fork
            begin
                for (int i = 0; i < 6; i++) push_code(codes[i], 60, waits[i]);
            end
            collect(125);
        join
        // Code 0 pops at once; codes 1..4 fill the FIFO; code 5 waits 14 cycles for the next pop.
        n_cmp++;
        if (waits[5] != 14 || waits[4] != 0 || waits[1] != 0) begin
            n_err++;
            $display("FAIL full_holdoff: got waits %0d/%0d/%0d want 0/0/14", waits[1], waits[4], waits[5]);
        end
        n_cmp++;
        if (sym_q.size() != 6) begin
            n_err++;
            $display("FAIL full_count: got %0d symbols want 6", sym_q.size());
        end
        for (int i = 0; i < sym_q.size() && i < 6; i++) begin
            n_cmp++;
            if (sym_q[i] !== (8'h01 << codes[i]) || len_q[i] != 15) begin
                n_err++;
                $display("FAIL full_sym %0d: got %h len %0d want %h len 15", i, sym_q[i], len_q[i], 8'h01 << codes[i]);
            end
        end
        for (int i = 1; i < start_q.size(); i++) begin
            n_cmp++;
            if (start_q[i] - start_q[i-1] != 17) begin
                n_err++;
                $display("FAIL full_spacing %0d: got %0d want 17", i, start_q[i] - start_q[i-1]);
            end
        end
        n_cmp++;
        if (ready_bad != 0 || shape_bad != 0 || max_level != 4) begin
            n_err++;
            $display("FAIL full_flow: got ready_bad=%0d shape_bad=%0d max_lvl=%0d want 0/0/4", ready_bad, shape_bad, max_level);
        end
    endtask

    task automatic test_back_to_back();
        int w;
        dwell = 4'd2;
        fork
            begin
                push_code(3'd4, 20, w);
                push_code(3'd1, 20, w);
                push_code(3'd7, 20, w);
            end
            collect(20);
        join
        n_cmp++;
        if (sym_q.size() != 3) begin
            n_err++;
            $display("FAIL b2b_count: got %0d want 3", sym_q.size());
        end else if ({sym_q[0], sym_q[1], sym_q[2]} !== {8'h10, 8'h02, 8'h80} ||
                     start_q[1] - start_q[0] != 4 || start_q[2] - start_q[1] != 4 ||
                     len_q[0] != 2 || len_q[2] != 2) begin
            n_err++;
            $display("FAIL b2b_seq: got %h %h %h gaps %0d %0d want 10 02 80 gaps 4 4",
                     sym_q[0], sym_q[1], sym_q[2], start_q[1] - start_q[0], start_q[2] - start_q[1]);
        end
    endtask

    task automatic test_mid_reset();
        int w;
        dwell = 4'd8;
        push_code(3'd6, 20, w);
        push_code(3'd1, 20, w);
        push_code(3'd2, 20, w);
        n_cmp++;
        if ({oct, oct_valid, fifo_level} !== {8'h40, 1'b1, 3'd2}) begin
            n_err++;
            $display("FAIL midrst_pre: got oct=%h v=%b lvl=%0d want 40/1/2", oct, oct_valid, fifo_level);
        end
        #3 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({oct, oct_valid, busy, fifo_level, in_ready} !== {8'h00, 1'b0, 1'b0, 3'd0, 1'b1}) begin
            n_err++;
            $display("FAIL midrst_async: got oct=%h v=%b busy=%b lvl=%0d rdy=%b want 00/0/0/0/1",
                     oct, oct_valid, busy, fifo_level, in_ready);
        end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        collect(30);
        n_cmp++;
        if (sym_q.size() != 0 || max_level != 0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_after: got %0d symbols max_lvl=%0d busy=%b want 0/0/0", sym_q.size(), max_level, busy);
        end
    endtask

`ifdef OCT_LOOPBACK_CHECK_EN
    task automatic test_loopback();
        int w;
        test_sweep();
        n_cmp++;
        if (err !== 1'b0) begin
            n_err++;
            $display("FAIL lb_clean: got err=%b want 0", err);
        end
        dwell = 4'd6;
        push_code(3'd3, 20, w);
        @(posedge clk); #1;
        force dut.oct_r = 8'h09;
        @(posedge clk); #1;
        release dut.oct_r;
        repeat (12) @(posedge clk);
        #1;
        n_cmp++;
        if (err !== 1'b1) begin
            n_err++;
            $display("FAIL lb_sticky: got err=%b want 1", err);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (err !== 1'b0) begin
            n_err++;
            $display("FAIL lb_reset: got err=%b want 0", err);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_sweep();
        test_fifo_full();
        test_back_to_back();
        test_mid_reset();
`ifdef OCT_LOOPBACK_CHECK_EN
        test_loopback();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
